// File: rtl/vcore_ppln_arb_if.sv
// Handshake bundle between NUM_REQ requesters, the arbiter stage and the downstream consumer.
// master = requesters plus consumer side, slave = arbiter.
interface vcore_ppln_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*CTRL_WIDTH-1:0] req_ctrl;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [CTRL_WIDTH-1:0]         out_ctrl;
    logic [ID_WIDTH-1:0]           out_src;
    logic                          out_last;

    modport master (
        output req_valid, req_last, req_data, req_ctrl, out_ready,
        input  req_ready, out_valid, out_data, out_ctrl, out_src, out_last
    );

    modport slave (
        input  req_valid, req_last, req_data, req_ctrl, out_ready,
        output req_ready, out_valid, out_data, out_ctrl, out_src, out_last
    );
endinterface

// File: rtl/vcore_ppln_arb.sv
// Round-robin arbiter feeding one registered valid/ready stage; the grant stays
// locked to a requester until the last beat of its packet transfers.
module vcore_ppln_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    vcore_ppln_arb_if.slave   bus,
    output logic              locked
);
    // state  | meaning
    // IDLE   | no packet in flight, round-robin scan from rr_ptr
    // LOCKED | mid-packet, only lock_id may transfer
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   lock_id, lock_id_nxt;
    logic [ID_WIDTH-1:0]   win;
    logic                  win_found;
    logic                  acc;
    logic                  xfer;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [CTRL_WIDTH-1:0] sel_ctrl;

    assign acc    = ~bus.out_valid | bus.out_ready;
    assign xfer   = acc & win_found;
    assign locked = (state == LOCKED);

    // Scan stays inside 0..NUM_REQ-1 so non-power-of-2 counts never grant a phantom index.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        if (state == LOCKED) begin
            win = lock_id;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ID_WIDTH'(i) == lock_id) win_found = bus.req_valid[i];
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!win_found && bus.req_valid[idx]) begin
                    win       = ID_WIDTH'(idx);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_last      = 1'b0;
        sel_data      = '0;
        sel_ctrl      = '0;
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == win) begin
                sel_last         = bus.req_last[i];
                sel_data         = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ctrl         = bus.req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
                bus.req_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_id_nxt = lock_id;
        if (xfer) begin
            if (sel_last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end else begin
                state_nxt   = LOCKED;
                lock_id_nxt = win;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lock_id       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ctrl  <= '0;
            bus.out_src   <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_id <= lock_id_nxt;
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_ctrl  <= sel_ctrl;
                bus.out_src   <= win;
                bus.out_last  <= sel_last;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    // Payload is left unreset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (xfer) bus.out_data <= sel_data;
    end
endmodule

// File: tb/tb_vcore_ppln_arb.sv
// Directed bench for vcore_ppln_arb: a 4-requester table plus hand-written reset and
// 3-requester wrap sequences.
module tb_vcore_ppln_arb;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NV = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic locked4, locked3;
    int   tests = 0;
    int   fails = 0;

    vcore_ppln_arb_if #(.NUM_REQ(4), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ID_WIDTH(2)) bus4 ();
    vcore_ppln_arb_if #(.NUM_REQ(3), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ID_WIDTH(2)) bus3 ();

    vcore_ppln_arb #(.NUM_REQ(4), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ID_WIDTH(2)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .locked(locked4)
    );
    vcore_ppln_arb #(.NUM_REQ(3), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ID_WIDTH(2)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .locked(locked3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] ready;
        logic       ov;
        logic [1:0] src;
        logic       olast;
        logic       lck;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [63:0] data_for(input int tag, input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(tag * 256 + i);
    endfunction

    function automatic logic [7:0] ctrl_for(input int tag, input int i);
        return 8'(tag * 4 + i + 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic ordy, input int tag);
        bus4.req_valid = v;
        bus4.req_last  = l;
        bus4.out_ready = ordy;
        for (int i = 0; i < 4; i++) begin
            bus4.req_data[i*DW +: DW] = data_for(tag, i);
            bus4.req_ctrl[i*CW +: CW] = ctrl_for(tag, i);
        end
    endtask

    task automatic step3(input int n, input logic [2:0] v, input logic [2:0] l,
                         input logic [2:0] exp_rdy, input logic exp_ov, input logic [1:0] exp_src);
        @(negedge clk);
        bus3.req_valid = v;
        bus3.req_last  = l;
        bus3.out_ready = 1'b1;
        #1;
        check($sformatf("n3_s%0d req_ready", n), 64'(bus3.req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        check($sformatf("n3_s%0d out_valid", n), 64'(bus3.out_valid), 64'(exp_ov));
        if (exp_ov) check($sformatf("n3_s%0d out_src", n), 64'(bus3.out_src), 64'(exp_src));
    endtask

    initial begin
        logic [63:0] exp_data;
        logic [7:0]  exp_ctrl;
        exp_data = '0;
        exp_ctrl = '0;

        //               valid    last     ordy  ready    ov    src   olast lck
        vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[6]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[7]  = '{4'b0110, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[13] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[14] = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[15] = '{4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[16] = '{4'b0011, 4'b0001, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[17] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[18] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[19] = '{4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[20] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};

        drive4(4'b0000, 4'b0000, 1'b0, 0);
        bus3.req_valid = '0;
        bus3.req_last  = '0;
        bus3.req_data  = '0;
        bus3.req_ctrl  = '0;
        bus3.out_ready = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("rst out_valid", 64'(bus4.out_valid), 64'd0);
        check("rst out_ctrl",  64'(bus4.out_ctrl),  64'd0);
        check("rst out_src",   64'(bus4.out_src),   64'd0);
        check("rst out_last",  64'(bus4.out_last),  64'd0);
        check("rst locked",    64'(locked4),        64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            drive4(vecs[v].valid, vecs[v].last, vecs[v].ordy, v);
            #1;
            check($sformatf("v%0d req_ready", v), 64'(bus4.req_ready), 64'(vecs[v].ready));
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].ready[i]) begin
                    exp_data = data_for(v, i);
                    exp_ctrl = ctrl_for(v, i);
                end
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", v), 64'(bus4.out_valid), 64'(vecs[v].ov));
            check($sformatf("v%0d out_src", v),   64'(bus4.out_src),   64'(vecs[v].src));
            check($sformatf("v%0d out_last", v),  64'(bus4.out_last),  64'(vecs[v].olast));
            check($sformatf("v%0d locked", v),    64'(locked4),        64'(vecs[v].lck));
            if (vecs[v].ov) begin
                check($sformatf("v%0d out_data", v), bus4.out_data,       exp_data);
                check($sformatf("v%0d out_ctrl", v), 64'(bus4.out_ctrl),  64'(exp_ctrl));
            end
        end

        // Reset in the middle of a locked packet from requester 2 (rr_ptr is 1 here).
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive4(4'b0101, 4'b0000, 1'b1, 30 + b);
            #1;
            check($sformatf("mid_rst beat%0d req_ready", b), 64'(bus4.req_ready), 64'(4'b0100));
            @(posedge clk);
            #1;
            check($sformatf("mid_rst beat%0d locked", b), 64'(locked4), 64'd1);
            check($sformatf("mid_rst beat%0d out_src", b), 64'(bus4.out_src), 64'd2);
        end
        #2 rst = 1'b1;
        drive4(4'b0000, 4'b0000, 1'b1, 0);
        #1;
        check("mid_rst out_valid", 64'(bus4.out_valid), 64'd0);
        check("mid_rst locked",    64'(locked4),        64'd0);
        check("mid_rst out_src",   64'(bus4.out_src),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive4(4'b0101, 4'b0101, 1'b1, 33);
        #1;
        check("post_rst req_ready", 64'(bus4.req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        check("post_rst out_src",   64'(bus4.out_src),   64'd0);
        check("post_rst out_valid", 64'(bus4.out_valid), 64'd1);
        check("post_rst out_data",  bus4.out_data,       data_for(33, 0));
        @(negedge clk);
        drive4(4'b0000, 4'b0000, 1'b1, 0);

        // Three requesters: pointer must wrap 2 -> 0, never visiting index 3.
        step3(1, 3'b100, 3'b100, 3'b100, 1'b1, 2'd2);
        step3(2, 3'b101, 3'b101, 3'b001, 1'b1, 2'd0);
        step3(3, 3'b111, 3'b111, 3'b010, 1'b1, 2'd1);
        step3(4, 3'b111, 3'b111, 3'b100, 1'b1, 2'd2);
        step3(5, 3'b111, 3'b111, 3'b001, 1'b1, 2'd0);
        step3(6, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vcore_ppln_arb.md
Name: vcore_ppln_arb

Overview:
- Round-robin arbiter that shares one registered valid/ready pipeline stage among NUM_REQ requesters.
- Supports multi-beat packets: once a requester wins, the grant is locked to it until its beat with req_last=1 transfers.
- Sits in front of vcore pipeline stages wherever several sources (e.g. LSU, PTW, prefetch) feed one downstream consumer.
- Output is a single register stage with 1-cycle latency.

Parameters:
- NUM_REQ, 4, number of requesters (>=2, need not be a power of 2)
- DATA_WIDTH, 64, payload width per beat (not reset)
- CTRL_WIDTH, 8, control sideband width per beat (reset to 0)
- ID_WIDTH, $clog2(NUM_REQ), width of the source index

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set
- req_last  input  NUM_REQ  beat is the final beat of the packet
- req_data  input  NUM_REQ*DATA_WIDTH  payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ctrl  input  NUM_REQ*CTRL_WIDTH  control, requester i at [i*CTRL_WIDTH +: CTRL_WIDTH]
- out_valid  output  1  stage holds a valid beat
- out_ready  input  1  downstream accepts
- out_data  output  DATA_WIDTH  registered payload
- out_ctrl  output  CTRL_WIDTH  registered control
- out_src  output  ID_WIDTH  requester index of the held beat
- out_last  output  1  registered last flag
- locked  output  1  high while in the LOCKED state

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_ctrl=0, out_src=0, out_last=0, locked=0.
  - State=IDLE, rr_ptr=0, lock_id=0.
  - out_data is not reset.
- Stage accept: acc = ~out_valid | out_ready (bubble-collapsing, no extra buffering).
- Winner selection (IDLE): win = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
- Winner selection (LOCKED): win = lock_id only; other requesters get req_ready=0 regardless of valid.
- req_ready[win] = acc & req_valid[win]; all other bits are 0. req_ready is combinational from req_valid and acc.
- Transfer: xfer = |(req_valid & req_ready). On xfer:
  - out_data, out_ctrl and out_last load the winner's inputs.
  - out_src loads win.
  - out_valid becomes 1.
- No transfer: if out_ready & out_valid, out_valid clears to 0. Otherwise registers hold.
- Throughput: one beat per cycle sustained when out_ready=1. Latency from request to out_valid is 1 cycle.
- State machine:
  - IDLE + xfer with req_last=0 -> LOCKED; lock_id=win.
  - IDLE + xfer with req_last=1 -> IDLE; rr_ptr=(win+1) mod NUM_REQ.
  - LOCKED + xfer with req_last=1 -> IDLE; rr_ptr=(lock_id+1) mod NUM_REQ.
  - LOCKED otherwise -> LOCKED. A locked requester dropping valid mid-packet stalls the arbiter; no timeout.
- rr_ptr changes only on a last-beat transfer, never on a stall.
- Wrap: when NUM_REQ is not a power of 2, the pointer and scan wrap at NUM_REQ-1 -> 0; indices >= NUM_REQ are never granted.
- Simultaneous out_ready & xfer: the old beat leaves and the new beat loads in the same cycle; out_valid stays 1.
- Requesters must hold valid, data, ctrl and last stable until ready. The arbiter does not re-arbitrate while acc=0: win is recomputed each cycle, but no state changes without xfer.
- Reset asserted mid-packet: lock is released, the stage empties, and rr_ptr returns to 0. Requesters must restart their packets.

Test Plan:
- Reset then all 4 requesters valid with single-beat packets and out_ready=1 -> grants in order 0,1,2,3,0. out_src follows the grant with 1-cycle latency. One beat per cycle.
- Requester 1 sends a 3-beat packet while requester 2 is valid -> req_ready[2]=0 and locked=1 until beat 3 of req 1 transfers. Then req 2 is granted and rr_ptr=2.
- out_ready=0 for 5 cycles with out_valid=1 -> all req_ready=0. out_data and out_src are held and rr_ptr is unchanged. Releasing out_ready accepts a new beat in the same cycle.
- NUM_REQ=3, only requester 2 valid with last=1 -> after the grant rr_ptr wraps to 0. The next grant to requester 0 occurs when both 0 and 2 are valid.
- rst pulse in the middle of a locked 4-beat packet -> outputs are immediately out_valid=0 and locked=0. After release, requester 0 wins first.
- Locked requester drops valid for 2 cycles mid-packet -> no other requester is granted and out_valid falls to 0. The packet resumes when valid returns.
